// File: rtl/fifo_batch_drainer.sv
// ---------------------------------------------------------------------------
// fifo_batch_drainer
//
// Read-side consumer for an async FIFO channel, living in the pop-clock
// domain. It watches the channel occupancy (fifo_pop_dw) and pops words in
// batches: a full batch of BATCH_SIZE words as soon as that many are
// available, or whatever is present once the FIFO has sat non-empty but
// below a batch for TIMEOUT_CYCLES idle cycles. Returned words are buffered
// in a small circular buffer and re-presented as a valid/ready stream.
// Pops are only issued when the buffer is guaranteed to have room for every
// word already on its way plus the new one, so the buffer cannot overflow.
//
// Ports:
//   clk              in   pop-side clock
//   rst_n            in   asynchronous active-low reset
//   fifo_pop_enable  out  registered pop request to the channel
//   fifo_pop_valid   in   channel word valid, one cycle after pop_enable
//   fifo_pop_data    in   channel word
//   fifo_pop_dw      in   channel occupancy
//   out_valid        out  output word valid (buffer non-empty)
//   out_data         out  output word (buffer head, zero when empty)
//   out_ready        in   downstream accept
//   error            out  sticky fault: unexpected word or buffer overflow
//
// Optional build macro FIFO_BATCH_DRAINER_STATS_EN adds stat_words,
// stat_batches and stat_timeouts free-running 32-bit counters.
// ---------------------------------------------------------------------------
module fifo_batch_drainer #(
    parameter int DATA_WIDTH     = 32,
    parameter int LOG_DEPTH      = 5,
    parameter int BATCH_SIZE     = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int OBUF_DEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fifo_pop_enable,
    input  logic                  fifo_pop_valid,
    input  logic [DATA_WIDTH-1:0] fifo_pop_data,
    input  logic [LOG_DEPTH-1:0]  fifo_pop_dw,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
`ifdef FIFO_BATCH_DRAINER_STATS_EN
    output logic [31:0]           stat_words,
    output logic [31:0]           stat_batches,
    output logic [31:0]           stat_timeouts,
`endif
    output logic                  error
);

    localparam int PTR_W = $clog2(OBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [LOG_DEPTH-1:0] quota_q, quota_d;
    logic [LOG_DEPTH-1:0] issued_q, issued_d;
    logic                 issue;

    // Two-stage issue pipeline: stage 0 is the cycle pop_enable is driven,
    // stage 1 is the cycle the channel answers.
    logic                 pop_en_q;
    logic                 ret_q;
    logic [1:0]           inflight;

    logic [DATA_WIDTH-1:0] obuf [OBUF_DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 error_q, error_d;
    logic                 obuf_full;
    logic                 wr_en;
    logic                 rd_en;
    logic                 credit_ok;

    assign inflight  = {1'b0, pop_en_q} + {1'b0, ret_q};
    assign obuf_full = (count_q == CNT_W'(OBUF_DEPTH));
    assign wr_en     = fifo_pop_valid && !obuf_full;
    assign rd_en     = out_valid && out_ready;
    // Reserve a slot for every word still on its way plus the new pop.
    assign credit_ok = (32'(count_q) + 32'(inflight) + 32'd1) <= 32'(OBUF_DEPTH);

    // ---------------- batch FSM ----------------
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        quota_d  = quota_q;
        issued_d = issued_q;
        issue    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_pop_dw >= LOG_DEPTH'(BATCH_SIZE)) begin
                    quota_d = LOG_DEPTH'(BATCH_SIZE);
                    timer_d = '0;
                    state_d = DRAIN;
                end else if (fifo_pop_dw != '0) begin
                    if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        quota_d = fifo_pop_dw;
                        timer_d = '0;
                        state_d = DRAIN;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end else begin
                    timer_d = '0;
                end
            end
            DRAIN: begin
                if (issued_q == quota_q) begin
                    state_d = FLUSH;
                end else if (credit_ok) begin
                    issue    = 1'b1;
                    issued_d = issued_q + 1'b1;
                end
            end
            FLUSH: begin
                if (inflight == 2'd0) begin
                    issued_d = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- output buffer bookkeeping ----------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        error_d  = error_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A word with no pop in its return slot, or one that finds the
        // buffer full, is a protocol fault; the overflow word is dropped.
        if (fifo_pop_valid && (!ret_q || obuf_full)) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            quota_q  <= '0;
            issued_q <= '0;
            pop_en_q <= 1'b0;
            ret_q    <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            quota_q  <= quota_d;
            issued_q <= issued_d;
            pop_en_q <= issue;
            ret_q    <= pop_en_q;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
        end
    end

    // Storage has no reset; out_data is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            obuf[wr_ptr_q] <= fifo_pop_data;
        end
    end

    assign fifo_pop_enable = pop_en_q;
    assign out_valid       = (count_q != '0);
    assign out_data        = out_valid ? obuf[rd_ptr_q] : '0;
    assign error           = error_q;

`ifdef FIFO_BATCH_DRAINER_STATS_EN
    logic        drain_entry;
    logic        timeout_entry;
    logic [31:0] stat_words_q, stat_batches_q, stat_timeouts_q;

    assign drain_entry   = (state_q == IDLE) && (state_d == DRAIN);
    assign timeout_entry = drain_entry && (fifo_pop_dw < LOG_DEPTH'(BATCH_SIZE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_words_q    <= '0;
            stat_batches_q  <= '0;
            stat_timeouts_q <= '0;
        end else begin
            if (fifo_pop_valid) stat_words_q    <= stat_words_q + 32'd1;
            if (drain_entry)    stat_batches_q  <= stat_batches_q + 32'd1;
            if (timeout_entry)  stat_timeouts_q <= stat_timeouts_q + 32'd1;
        end
    end

    assign stat_words    = stat_words_q;
    assign stat_batches  = stat_batches_q;
    assign stat_timeouts = stat_timeouts_q;
`endif

endmodule

// File: tb/tb_fifo_batch_drainer.sv
module tb_fifo_batch_drainer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_pop_enable;
    logic        fifo_pop_valid;
    logic [31:0] fifo_pop_data;
    logic [4:0]  fifo_pop_dw;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        error;

    int vectors = 0;
    int errors  = 0;

    // Channel model state
    logic [31:0] chan_q[$];
    logic [31:0] rx_q[$];
    int          pops;
    int          dw_force;
    logic        en_prev;
    logic        spurious;

    always #5 clk = ~clk;

    fifo_batch_drainer #(
        .DATA_WIDTH    (32),
        .LOG_DEPTH     (5),
        .BATCH_SIZE    (4),
        .TIMEOUT_CYCLES(64),
        .OBUF_DEPTH    (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_pop_enable(fifo_pop_enable),
        .fifo_pop_valid (fifo_pop_valid),
        .fifo_pop_data  (fifo_pop_data),
        .fifo_pop_dw    (fifo_pop_dw),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .error          (error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: record any accepted output word, advance, then act as the
    // channel (answer the pop_enable seen during the previous cycle).
    task automatic tick();
        if (out_valid && out_ready) rx_q.push_back(out_data);
        @(posedge clk);
        #1;
        if (en_prev && chan_q.size() > 0) begin
            fifo_pop_valid = 1'b1;
            fifo_pop_data  = chan_q.pop_front();
        end else if (spurious) begin
            fifo_pop_valid = 1'b1;
            fifo_pop_data  = 32'hDEAD;
            spurious       = 1'b0;
        end else begin
            fifo_pop_valid = 1'b0;
        end
        fifo_pop_dw = (dw_force >= 0) ? 5'(dw_force) : 5'(chan_q.size());
        en_prev     = fifo_pop_enable;
        if (fifo_pop_enable) pops++;
    endtask

    task automatic push_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) chan_q.push_back(base + 32'(i));
        fifo_pop_dw = 5'(chan_q.size());
    endtask

    task automatic check_rx(input string tag, input logic [31:0] base, input int n);
        check({tag, "_count"}, 32'(rx_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < rx_q.size()) check($sformatf("%s_w%0d", tag, i), rx_q[i], base + 32'(i));
            else check($sformatf("%s_w%0d", tag, i), 32'hFFFF_FFFF, base + 32'(i));
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        fifo_pop_valid = 1'b0;
        fifo_pop_data  = '0;
        fifo_pop_dw    = '0;
        out_ready      = 1'b1;
        pops           = 0;
        dw_force       = -1;
        en_prev        = 1'b0;
        spurious       = 1'b0;

        // ---- reset state ----
        repeat (3) tick();
        check("rst_pop_enable", 32'(fifo_pop_enable), 32'd0);
        check("rst_out_valid",  32'(out_valid),       32'd0);
        check("rst_out_data",   out_data,             32'd0);
        check("rst_error",      32'(error),           32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // ---- full batch ----
        pops = 0; rx_q.delete();
        push_words(32'hA0, 4);
        repeat (40) tick();
        check("full_pops",  32'(pops),  32'd4);
        check_rx("full", 32'hA0, 4);
        check("full_error", 32'(error), 32'd0);

        // ---- partial batch after timeout ----
        pops = 0; rx_q.delete();
        push_words(32'hB0, 2);
        repeat (63) tick();
        check("part_no_pop_63", 32'(pops), 32'd0);
        repeat (30) tick();
        check("part_pops", 32'(pops), 32'd2);
        check_rx("part", 32'hB0, 2);

        // ---- backpressure: credit holds issue at four buffered words ----
        pops = 0; rx_q.delete();
        out_ready = 1'b0;
        push_words(32'hC0, 8);
        repeat (30) tick();
        check("bp_pops_stalled", 32'(pops),      32'd4);
        check("bp_out_valid",    32'(out_valid), 32'd1);
        check("bp_head",         out_data,       32'hC0);
        check("bp_error",        32'(error),     32'd0);
        out_ready = 1'b1;
        repeat (60) tick();
        check("bp_pops_total", 32'(pops), 32'd8);
        check_rx("bp", 32'hC0, 8);

        // ---- empty return: occupancy claims 3, only 2 words exist ----
        pops = 0; rx_q.delete();
        dw_force = 3;
        push_words(32'hD0, 2);
        fifo_pop_dw = 5'd3;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (pops > 0) dw_force = -1;
        end
        check("empty_pops",  32'(pops),            32'd3);
        check_rx("empty", 32'hD0, 2);
        check("empty_error", 32'(error),           32'd0);
        check("empty_idle",  32'(fifo_pop_enable), 32'd0);

        // ---- spurious valid sets sticky error ----
        spurious = 1'b1;
        tick();
        tick();
        check("spur_error", 32'(error), 32'd1);
        repeat (5) tick();
        check("spur_sticky", 32'(error), 32'd1);

        // ---- reset in the middle of a drain ----
        pops = 0; rx_q.delete();
        push_words(32'hF0, 4);
        for (int i = 0; i < 20 && pops < 1; i++) tick();
        check("mid_one_pop", 32'(pops), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_enable", 32'(fifo_pop_enable), 32'd0);
        check("mid_rst_valid",  32'(out_valid),       32'd0);
        check("mid_rst_error",  32'(error),           32'd0);
        chan_q.delete();
        en_prev = 1'b0;
        fifo_pop_dw = '0;
        pops = 0;
        repeat (3) tick();
        check("mid_hold_pops",  32'(pops),      32'd0);
        check("mid_hold_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        repeat (5) tick();
        check("post_rst_pops",  32'(pops),  32'd0);
        check("post_rst_error", 32'(error), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
